// File: rtl/musb_uart_rx_fifo.sv
// 8N1 UART receiver (2-flop synchronizer, mid-bit sampling, glitch reject) feeding a show-ahead byte FIFO.
// Latency: byte visible on rx_valid/rx_count the cycle after its stop-bit sample; pop updates rx_data next cycle.
// Backpressure: none toward the line; a byte arriving while full with no pop is dropped and sets sticky overflow.
module musb_uart_rx_fifo #(
  parameter int BUS_FREQ        = 100,
  parameter int BAUD            = 115200,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rx,
  input  logic                     rx_pop,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic [FIFO_ADDR_WIDTH:0] rx_count,
  output logic                     rx_busy,
  output logic                     frame_error,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int CLKS_PER_BIT = BUS_FREQ * 1_000_000 / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = FIFO_ADDR_WIDTH;
  localparam int DEPTH        = 1 << AW;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic          rx_meta;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;

  logic          cnt_last;
  logic          cnt_half;
  logic          stop_sample;
  logic          push;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;

  // Two-flop synchronizer, preset to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Sampling points and the byte-complete event derived from the receiver state.
  always_comb begin
    cnt_last    = (cnt == CNT_LAST);
    cnt_half    = (cnt == CNT_HALF);
    stop_sample = (state == ST_STOP) && cnt_last;
    push        = stop_sample && rx_s;
  end

  // Receiver FSM: start detect, half-bit start check, eight data bits LSB-first, stop check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= stop_sample && !rx_s;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt_half) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line already back high at mid-start was a glitch: drop it silently.
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_last) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO status; a push into a full FIFO is still taken when the head is popped in the same cycle.
  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_pop  = rx_pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= shreg;
    end
  end

  // Pointers and sticky overflow; setting overflow takes priority over clearing it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && full && !rx_pop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Show-ahead head byte (forced to zero when empty so reset reads back clean) and status outputs.
  always_comb begin
    rx_valid = !empty;
    rx_count = wptr - rptr;
    rx_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];
    rx_busy  = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_musb_uart_rx_fifo.sv
// Bench for musb_uart_rx_fifo: directed frames, glitches, framing errors, overflow, reset, then random traffic.
// Expected values come from a byte-queue model of the FIFO plus frame timing derived from the bit period.
// Runs at 16 clocks per bit (BUS_FREQ=16 MHz, BAUD=1 Mbit/s) to keep the run short.
module tb_musb_uart_rx_fifo;

  localparam int C     = 16;
  localparam int H     = C / 2;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic       rx_pop;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       rx_busy;
  logic       frame_error;
  logic       overflow;
  logic       overflow_clr;

  musb_uart_rx_fifo #(
    .BUS_FREQ       (16),
    .BAUD           (1_000_000),
    .FIFO_ADDR_WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_pop      (rx_pop),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_count    (rx_count),
    .rx_busy     (rx_busy),
    .frame_error (frame_error),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents and sticky overflow flag.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  // Cycle counter and event monitors.
  int   cyc = 0;
  int   t_start = 0;
  int   rise_cyc = -1;
  logic prev_v = 1'b0;
  int   fe_run = 0;
  int   fe_pulses = 0;
  int   fe_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = rx_valid;
    if (frame_error) begin
      fe_run = fe_run + 1;
    end else if (fe_run != 0) begin
      fe_pulses = fe_pulses + 1;
      if (fe_run > fe_max) fe_max = fe_run;
      fe_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] m_head();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(rx_count), 32'(q.size()));
    check({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
    check({tag, "_data"},  32'(rx_data),  32'(m_head()));
    check({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
    check({tag, "_busy"},  32'(rx_busy),  32'd0);
  endtask

  // Hold the line at v for n clocks, changing it on a falling edge.
  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    uart_rx = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    uart_rx = 1'b0;
    t_start = cyc;
    repeat (C - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], C);
    drive_bit(stop_ok, C);
  endtask

  task automatic do_pops(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("pop_head", 32'(rx_data), 32'(m_head()));
      rx_pop = 1'b1;
      if (q.size() != 0) void'(q.pop_front());
    end
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic glitch(input int len, input logic exact);
    int k;
    @(negedge clk);
    uart_rx = 1'b0;
    k = cyc;
    repeat (len) @(negedge clk);
    uart_rx = 1'b1;
    if (exact) begin
      while (cyc < k + 2 + H) @(negedge clk);
      check("glitch_busy_in_start", 32'(rx_busy), 32'd1);
      @(negedge clk);
      check("glitch_idle_at_half", 32'(rx_busy), 32'd0);
    end
    repeat (C) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe_before;
    int r;
    logic [7:0] b;

    rst = 1'b0;
    uart_rx = 1'b1;
    rx_pop = 1'b0;
    overflow_clr = 1'b0;
    repeat (4) @(negedge clk);
    check_state("reset");
    check("reset_fe", 32'(frame_error), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single byte, push latency, pop, pop-when-empty.
    send(8'hA5, 1'b1);
    m_push(8'hA5);
    check("t1_latency", 32'(rise_cyc), 32'(t_start + 3 + H + 9 * C));
    check("t1_byte", 32'(rx_data), 32'h0000_00A5);
    check_state("t1");
    do_pops(1);
    check_state("t1_popped");
    do_pops(1);
    check_state("t1_pop_empty");

    // 2: short low pulse rejected at half bit.
    fe_before = fe_pulses;
    glitch(H - 3, 1'b1);
    check_state("t2");
    check("t2_no_fe", 32'(fe_pulses), 32'(fe_before));

    // 3: stop bit low -> one-cycle frame_error, byte dropped.
    fe_before = fe_pulses;
    fe_max = 0;
    send(8'h3C, 1'b0);
    drive_bit(1'b1, C);
    check("t3_fe_pulses", 32'(fe_pulses), 32'(fe_before + 1));
    check("t3_fe_width", 32'(fe_max), 32'd1);
    check_state("t3");

    // 4: 17 back-to-back bytes with no pops -> full plus overflow.
    for (int i = 0; i <= 16; i++) begin
      send(8'(i), 1'b1);
      m_push(8'(i));
    end
    check("t4_count16", 32'(rx_count), 32'd16);
    check("t4_ovf", 32'(overflow), 32'd1);
    check_state("t4");
    do_pops(16);
    check_state("t4_drained");
    clear_ovf();
    check_state("t4_ovf_clr");

    // 5: refill, 17th stop sample coincides with a pop -> no overflow.
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b1);
      m_push(8'(i));
    end
    check_state("t5_full");
    fork
      send(8'h10, 1'b1);
      begin
        repeat (3 + H + 9 * C) @(negedge clk);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
      end
    join
    void'(q.pop_front());
    m_push(8'h10);
    check("t5_count", 32'(rx_count), 32'd16);
    check("t5_ovf", 32'(overflow), 32'd0);
    check_state("t5");
    do_pops(15);
    check("t5_last", 32'(rx_data), 32'h0000_0010);

    // 6: reset during DATA of 0x55, then 0x81.
    drive_bit(1'b0, C);
    drive_bit(1'b1, C);
    drive_bit(1'b0, C);
    drive_bit(1'b1, C);
    check("t6_busy_before", 32'(rx_busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    uart_rx = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_state("t6_in_reset");
    check("t6_fe", 32'(frame_error), 32'd0);
    repeat (C) @(negedge clk);
    check_state("t6_held");
    rst = 1'b1;
    repeat (2 * C) @(negedge clk);
    check_state("t6_released");
    send(8'h81, 1'b1);
    m_push(8'h81);
    check_state("t6_rx");
    do_pops(1);
    check_state("t6_done");

    // Random traffic against the queue model.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        b = 8'($urandom);
        send(b, 1'b1);
        m_push(b);
      end else if (r == 6) begin
        fe_before = fe_pulses;
        fe_max = 0;
        send(8'($urandom), 1'b0);
        drive_bit(1'b1, C);
        check("rnd_fe_pulse", 32'(fe_pulses), 32'(fe_before + 1));
        check("rnd_fe_width", 32'(fe_max), 32'd1);
      end else if (r == 7) begin
        glitch($urandom_range(1, H - 2), 1'b0);
      end else if (r == 8) begin
        do_pops($urandom_range(1, 6));
      end else begin
        clear_ovf();
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
      check_state("rnd");
    end

    do_pops(DEPTH + 1);
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
